// File: rtl/uart_rx2x.sv
// uart_rx2x -- asynchronous serial receiver (8N1-style, LSB first) with a
// DL11-like done/read handshake.
//
// Ports
//   clk          system clock
//   async_reset  asynchronous, active-high reset
//   tick         1-clk enable at twice the baud rate
//   rx           serial line, already synchronised; idle = 1
//   rd           1-clk read strobe; clears done and overrun
//   data         last received character
//   done         character available, not yet read
//   overrun      a character completed while done was still set (sticky)
//   ferr         framing error (stop bit sampled low) on last character
//   busy         receiver FSM not in IDLE
//
// Handshake: done rises one clk after the stop-bit sample and stays high until
// a clk with rd=1 and no simultaneous completion. A completion in the same clk
// as rd wins: done stays high and overrun is cleared.
module uart_rx2x #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 async_reset,
    input  logic                 tick,
    input  logic                 rx,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] data,
    output logic                 done,
    output logic                 overrun,
    output logic                 ferr,
    output logic                 busy
);

    localparam int CW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_sample_data;
    logic                   w_sample_stop;

    logic [DATA_BITS-1:0]   r_shift;
    logic [CW-1:0]          r_bitcnt;
    logic                   r_half;
    logic                   r_cpl;        // stop bit sampled last clk
    logic                   r_stop_bit;   // value of that stop sample
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_done;
    logic                   r_overrun;
    logic                   r_ferr;

    // State register
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state; nothing moves on clks without a tick.
    always_comb begin
        w_state_next  = r_state;
        w_sample_data = 1'b0;
        w_sample_stop = 1'b0;
        if (tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!rx) w_state_next = S_START;
                end
                S_START: begin
                    w_state_next = rx ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    // r_half=1 marks the mid-bit tick of the current data bit
                    if (r_half) begin
                        w_sample_data = 1'b1;
                        if (r_bitcnt == CW'(DATA_BITS - 1)) w_state_next = S_STOP;
                    end
                end
                S_STOP: begin
                    if (r_half) begin
                        w_sample_stop = 1'b1;
                        w_state_next  = rx ? S_IDLE : S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (rx) w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Shift register, bit counter and half-bit phase
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_half     <= 1'b0;
            r_cpl      <= 1'b0;
            r_stop_bit <= 1'b0;
        end else begin
            r_cpl <= w_sample_stop;
            if (w_sample_stop) r_stop_bit <= rx;
            if (tick) begin
                case (r_state)
                    S_START: begin
                        r_bitcnt <= '0;
                        r_half   <= 1'b0;
                    end
                    S_DATA: begin
                        // after the last sample r_half returns to 0, which is
                        // the phase STOP needs to sample two ticks later
                        r_half <= ~r_half;
                        if (w_sample_data) begin
                            r_shift  <= {rx, r_shift[DATA_BITS-1:1]};
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        r_half <= ~r_half;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Status / handshake registers, evaluated every clk
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_data    <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_ferr    <= 1'b0;
        end else if (r_cpl) begin
            r_data <= r_shift;
            r_ferr <= ~r_stop_bit;
            r_done <= 1'b1;
            if (rd) begin
                r_overrun <= 1'b0;
            end else if (r_done) begin
                r_overrun <= 1'b1;
            end
        end else if (rd) begin
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign data    = r_data;
    assign done    = r_done;
    assign overrun = r_overrun;
    assign ferr    = r_ferr;
    assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx2x.sv
// Testbench for uart_rx2x: directed characters driven on rx, expected
// {ferr,data} words pushed into a queue at send time, and a monitor that pops
// and compares whenever the DUT presents a new character.
module tb_uart_rx2x;

    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          async_reset;
    logic          tick = 1'b0;
    logic          rx;
    logic          rd;
    logic [DB-1:0] data;
    logic          done;
    logic          overrun;
    logic          ferr;
    logic          busy;

    int   checks = 0;
    int   errors = 0;
    int   tick_cnt = 0;
    bit   tick_const = 1'b0;
    int   bit_clk = 8;

    logic [DB:0] exp_q[$];

    uart_rx2x #(.DATA_BITS(DB)) dut (
        .clk         (clk),
        .async_reset (async_reset),
        .tick        (tick),
        .rx          (rx),
        .rd          (rd),
        .data        (data),
        .done        (done),
        .overrun     (overrun),
        .ferr        (ferr),
        .busy        (busy)
    );

    // ---------------- clock / tick ----------------
    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick_cnt = (tick_cnt == 3) ? 0 : tick_cnt + 1;
        tick     = tick_const ? 1'b1 : (tick_cnt == 0);
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        idle_clk(bit_clk);
    endtask

    task automatic send_data(input logic [DB-1:0] c);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(c[i]);
    endtask

    task automatic send_char(input logic [DB-1:0] c);
        exp_q.push_back({1'b0, c});
        send_data(c);
        drive_bit(1'b1);
        idle_clk(4);
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic        prev_done = 1'b0;
    logic [DB:0] prev_word = '0;

    always @(negedge clk) begin
        if (async_reset !== 1'b1) begin
            if (done === 1'b1 && (prev_done !== 1'b1 || {ferr, data} !== prev_word)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_char: got {ferr,data}=0x%0h expected none", {ferr, data});
                end else begin
                    check("char", 32'({ferr, data}), 32'(exp_q.pop_front()));
                end
            end
        end
        prev_done = done;
        prev_word = {ferr, data};
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int  n;
        bit  seen_busy;

        async_reset = 1'b1;
        rx          = 1'b1;
        rd          = 1'b0;
        idle_clk(3);
        check("reset_outputs_in_reset", 32'({data, done, overrun, ferr, busy}), 32'h0);
        async_reset = 1'b0;
        idle_clk(4);
        check("reset_outputs_after", 32'({data, done, overrun, ferr, busy}), 32'h0);

        // 1: clean 0xA5
        send_char(8'hA5);
        check("t1_done", 32'(done), 32'h1);
        check("t1_ferr", 32'(ferr), 32'h0);
        check("t1_overrun", 32'(overrun), 32'h0);
        check("t1_busy", 32'(busy), 32'h0);
        pulse_rd();
        check("t1_done_after_rd", 32'(done), 32'h0);
        check("t1_data_held", 32'(data), 32'hA5);

        // 2: false start, low for exactly one tick period
        seen_busy = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        rx = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        check("t2_busy_seen", 32'(seen_busy), 32'h1);
        check("t2_busy_dropped", 32'(busy), 32'h0);
        check("t2_done", 32'(done), 32'h0);

        // 3: 0x3C with low stop bit, line held low for 20 bits
        exp_q.push_back({1'b1, 8'h3C});
        send_data(8'h3C);
        rx = 1'b0;
        idle_clk(10 * bit_clk);
        check("t3_done", 32'(done), 32'h1);
        check("t3_ferr", 32'(ferr), 32'h1);
        check("t3_busy_in_break", 32'(busy), 32'h1);
        idle_clk(10 * bit_clk);
        check("t3_busy_still_break", 32'(busy), 32'h1);
        check("t3_overrun", 32'(overrun), 32'h0);
        rx = 1'b1;
        idle_clk(12);
        check("t3_busy_released", 32'(busy), 32'h0);
        check("t3_data", 32'(data), 32'h3C);
        pulse_rd();

        // 4: two characters without a read -> overrun
        send_char(8'h11);
        send_char(8'h22);
        check("t4_done", 32'(done), 32'h1);
        check("t4_overrun", 32'(overrun), 32'h1);
        check("t4_ferr", 32'(ferr), 32'h0);
        pulse_rd();
        check("t4_done_cleared", 32'(done), 32'h0);
        check("t4_overrun_cleared", 32'(overrun), 32'h0);
        check("t4_data_held", 32'(data), 32'h22);

        // 5: rd in the completion clk of the second character
        send_char(8'h33);
        check("t5_first_done", 32'(done), 32'h1);
        exp_q.push_back({1'b0, 8'h44});
        fork
            begin
                send_data(8'h44);
                drive_bit(1'b1);
                idle_clk(4);
            end
            begin
                n = 0;
                @(negedge clk);
                while (!busy && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                while (busy && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                check("t5_busy_wait_timeout", 32'(n < 400), 32'h1);
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
            end
        join
        check("t5_done", 32'(done), 32'h1);
        check("t5_overrun", 32'(overrun), 32'h0);
        check("t5_data", 32'(data), 32'h44);

        // 6: reset in the middle of 0xFF data bits
        rx = 1'b0;
        idle_clk(bit_clk);
        rx = 1'b1;
        idle_clk(3 * bit_clk);
        check("t6_busy_before_reset", 32'(busy), 32'h1);
        #2;
        async_reset = 1'b1;
        #1;
        check("t6_outputs_reset", 32'({data, done, overrun, ferr, busy}), 32'h0);
        idle_clk(2);
        async_reset = 1'b0;
        idle_clk(16);
        check("t6_no_partial_char", 32'({data, done, busy}), 32'h0);
        send_char(8'h55);
        check("t6_done_055", 32'(done), 32'h1);
        check("t6_overrun_055", 32'(overrun), 32'h0);
        pulse_rd();

        // 7: tick held high, 2 clk per bit
        tick_const = 1'b1;
        bit_clk    = 2;
        idle_clk(2);
        send_char(8'h96);
        check("t7_done", 32'(done), 32'h1);
        check("t7_ferr", 32'(ferr), 32'h0);
        check("t7_busy", 32'(busy), 32'h0);

        idle_clk(4);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
